// File: rtl/c64_pkg.sv
// rtl/c64_pkg.sv - shared C64 bus widths, DMA arbiter defaults and state type
package c64_pkg;

   localparam int C64_ADDR_W         = 16;
   localparam int C64_DATA_W         = 8;
   localparam int DMA_BURST_MAX_DEF  = 16;
   localparam int DMA_BA_TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      XFER,
      NEXT,
      RELEASE
   } dma_arb_state_t;

endpackage

// File: rtl/c64_dma_bus_arbiter_if.sv
// rtl/c64_dma_bus_arbiter_if.sv - requester and core-side signals of the DMA arbiter
interface c64_dma_bus_arbiter_if;
   import c64_pkg::*;

   logic                  phi2;
   logic                  ba;
   logic [1:0]            req;
   logic [1:0]            req_we;
   logic [C64_ADDR_W-1:0] req_addr0;
   logic [C64_ADDR_W-1:0] req_addr1;
   logic [C64_DATA_W-1:0] req_wdata0;
   logic [C64_DATA_W-1:0] req_wdata1;
   logic [1:0]            ack;
   logic [1:0]            err;
   logic [C64_DATA_W-1:0] rdata;
   logic                  dma;
   logic [C64_ADDR_W-1:0] bus_addr;
   logic                  bus_we;
   logic [C64_DATA_W-1:0] bus_wdata;
   logic [C64_DATA_W-1:0] bus_rdata;

   modport master (
      input  phi2, ba, req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, bus_rdata,
      output ack, err, rdata, dma, bus_addr, bus_we, bus_wdata
   );

   modport slave (
      output phi2, ba, req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, bus_rdata,
      input  ack, err, rdata, dma, bus_addr, bus_we, bus_wdata
   );

endinterface

// File: rtl/phi2_edge.sv
// rtl/phi2_edge.sv - one-clk rise/fall pulses of phi2 in the dot-clock domain
// phi2_q is left unreset so a reset during phi2 high cannot fake an edge.
module phi2_edge (
   input  logic clk,
   input  logic phi2_i,
   output logic rise_o,
   output logic fall_o
);

   logic phi2_q;

   always_ff @(posedge clk) begin
      phi2_q <= phi2_i;
   end

   assign rise_o = phi2_i & ~phi2_q;
   assign fall_o = ~phi2_i & phi2_q;

endmodule

// File: rtl/c64_dma_bus_arbiter.sv
// rtl/c64_dma_bus_arbiter.sv - round-robin DMA arbiter for the C64 expansion-port bus
// Grants one phi2-aligned bus cycle per transfer, optionally chaining a short burst.
module c64_dma_bus_arbiter
   import c64_pkg::*;
#(
   parameter int BURST_MAX  = DMA_BURST_MAX_DEF,
   parameter int BA_TIMEOUT = DMA_BA_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   c64_dma_bus_arbiter_if.master bus
);

   localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam int TW = $clog2(BA_TIMEOUT + 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(BA_TIMEOUT - 1);

   dma_arb_state_t        state_q;
   logic                  win_q;
   logic                  last_q;
   logic [BW-1:0]         burst_q;
   logic [TW-1:0]         tmo_q;
   logic [C64_ADDR_W-1:0] addr_q;
   logic                  we_q;
   logic [C64_DATA_W-1:0] wdata_q;
   logic                  dma_q;
   logic [1:0]            ack_q;
   logic [1:0]            err_q;
   logic [C64_DATA_W-1:0] rdata_q;
   logic [C64_ADDR_W-1:0] bus_addr_q;
   logic                  bus_we_q;
   logic [C64_DATA_W-1:0] bus_wdata_q;

   logic                  rise;
   logic                  fall;
   logic                  pick_d;
   logic                  src_idx;
   logic [C64_ADDR_W-1:0] src_addr;
   logic [C64_DATA_W-1:0] src_wdata;
   logic                  src_we;
   logic                  other_idle;

   phi2_edge u_phi2_edge (
      .clk    (clk),
      .phi2_i (bus.phi2),
      .rise_o (rise),
      .fall_o (fall)
   );

   // On a tie the index not served last wins; otherwise the lone requester wins.
   always_comb begin
      pick_d = bus.req[1];
      if (bus.req[0] && bus.req[1]) begin
         pick_d = ~last_q;
      end
      src_idx   = (state_q == IDLE) ? pick_d : win_q;
      src_addr  = src_idx ? bus.req_addr1 : bus.req_addr0;
      src_wdata = src_idx ? bus.req_wdata1 : bus.req_wdata0;
      src_we    = bus.req_we[src_idx];
   end

   assign other_idle = ~bus.req[~win_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         last_q      <= 1'b1;
         burst_q     <= '0;
         tmo_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         dma_q       <= 1'b0;
         ack_q       <= '0;
         err_q       <= '0;
         rdata_q     <= '0;
         bus_addr_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_wdata_q <= '0;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  win_q   <= pick_d;
                  addr_q  <= src_addr;
                  we_q    <= src_we;
                  wdata_q <= src_wdata;
                  tmo_q   <= '0;
                  dma_q   <= 1'b1;
                  state_q <= ARM;
               end
            end
            ARM: begin
               if (rise) begin
                  if (!bus.ba) begin
                     bus_addr_q  <= addr_q;
                     bus_we_q    <= we_q;
                     bus_wdata_q <= we_q ? wdata_q : '0;
                     state_q     <= XFER;
                  end else begin
                     tmo_q <= tmo_q + TW'(1);
                     if (tmo_q == TMO_LAST) begin
                        err_q[win_q] <= 1'b1;
                        state_q      <= RELEASE;
                     end
                  end
               end
            end
            XFER: begin
               if (fall) begin
                  if (!we_q) begin
                     rdata_q <= bus.bus_rdata;
                  end
                  ack_q[win_q] <= 1'b1;
                  bus_addr_q   <= '0;
                  bus_we_q     <= 1'b0;
                  bus_wdata_q  <= '0;
                  state_q      <= NEXT;
               end
            end
            NEXT: begin
               if (bus.req[win_q] && (burst_q < BURST_LAST) && other_idle) begin
                  addr_q  <= src_addr;
                  we_q    <= src_we;
                  wdata_q <= src_wdata;
                  burst_q <= burst_q + BW'(1);
                  tmo_q   <= '0;
                  state_q <= ARM;
               end else begin
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               dma_q   <= 1'b0;
               last_q  <= win_q;
               burst_q <= '0;
               tmo_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.dma       = dma_q;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_c64_dma_bus_arbiter.sv
// tb/tb_c64_dma_bus_arbiter.sv - self-checking bench for c64_dma_bus_arbiter
module tb_c64_dma_bus_arbiter;
   import c64_pkg::*;

   localparam int BURST_MAX  = 4;
   localparam int BA_TIMEOUT = 4;
   localparam int WAIT_MAX   = 400;

   typedef struct {
      int          idx;
      bit          we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
   } vec_t;

   typedef struct {
      logic [1:0] ack;
      logic [1:0] err;
      logic [7:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   c64_dma_bus_arbiter_if bus_if ();

   c64_dma_bus_arbiter #(
      .BURST_MAX  (BURST_MAX),
      .BA_TIMEOUT (BA_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_of(input logic [15:0] a);
      if (a == 16'hD020) return 8'h0E;
      return a[7:0] ^ a[15:8];
   endfunction

   assign bus_if.bus_rdata = mem_of(bus_if.bus_addr);

   initial begin
      bus_if.phi2 = 1'b0;
      forever begin
         repeat (4) @(posedge clk);
         #1 bus_if.phi2 = ~bus_if.phi2;
      end
   end

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        vecs[6];
   logic [1:0]  a, e;
   int          st_we, st_leak, st_low, st_rise, glitch_n, ack_cnt;
   logic [15:0] st_addr;
   logic [7:0]  st_wdata;
   logic        st_dma1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int idx, input bit is_err, input logic [7:0] rd);
      exp_t x;
      x.ack = 2'b00;
      x.err = 2'b00;
      if (is_err) x.err[idx] = 1'b1;
      else x.ack[idx] = 1'b1;
      x.rdata = rd;
      sb.push_back(x);
   endtask

   task automatic drive_req(input int idx, input bit we, input logic [15:0] addr,
                            input logic [7:0] wd);
      if (idx == 0) begin
         bus_if.req_addr0  = addr;
         bus_if.req_wdata0 = wd;
      end else begin
         bus_if.req_addr1  = addr;
         bus_if.req_wdata1 = wd;
      end
      bus_if.req_we[idx] = we;
      bus_if.req[idx]    = 1'b1;
   endtask

   // Walks negedges until ack/err, gathering what the bus did along the way.
   task automatic wait_resp(output logic [1:0] ra, output logic [1:0] re);
      int   n;
      logic prev;
      n = 0;
      ra = 2'b00;
      re = 2'b00;
      st_we = 0; st_leak = 0; st_low = 0; st_rise = 0;
      st_addr = '0; st_wdata = '0; st_dma1 = 1'b0;
      prev = bus_if.phi2;
      while (n < WAIT_MAX) begin
         @(negedge clk);
         n++;
         if (bus_if.bus_we) begin
            st_we++;
            st_wdata = bus_if.bus_wdata;
         end else if (bus_if.bus_wdata != 8'h00) begin
            st_leak++;
         end
         if (bus_if.phi2 && bus_if.dma) st_addr = bus_if.bus_addr;
         if (!bus_if.dma) st_low++;
         if (bus_if.phi2 && !prev && bus_if.dma) st_rise++;
         if (n == 1) st_dma1 = bus_if.dma;
         prev = bus_if.phi2;
         if (bus_if.ack != 2'b00 || bus_if.err != 2'b00) begin
            ra = bus_if.ack;
            re = bus_if.err;
            break;
         end
      end
      check("resp_within_budget", {ra, re} != 4'b0000, 1'b1);
   endtask

   always @(negedge clk) begin
      if (!reset && (bus_if.ack != 2'b00 || bus_if.err != 2'b00)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected", {bus_if.ack, bus_if.err}, 4'b0000);
         end else begin
            mon_e = sb.pop_front();
            check("sb_resp", {bus_if.ack, bus_if.err}, {mon_e.ack, mon_e.err});
            if (mon_e.ack != 2'b00) check("sb_rdata", bus_if.rdata, mon_e.rdata);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 1'b0, 16'hD020, 8'h00, 8'h0E};
      vecs[1] = '{1, 1'b1, 16'h0801, 8'hA5, 8'h0E};
      vecs[2] = '{0, 1'b0, 16'h1234, 8'h00, 8'h26};
      vecs[3] = '{1, 1'b0, 16'hC0DE, 8'h00, 8'h1E};
      vecs[4] = '{0, 1'b1, 16'h0000, 8'h3C, 8'h1E};
      vecs[5] = '{1, 1'b0, 16'hA0FF, 8'h00, 8'h5F};

      reset = 1'b1;
      bus_if.ba = 1'b0;
      bus_if.req = 2'b00;
      bus_if.req_we = 2'b00;
      bus_if.req_addr0 = '0;
      bus_if.req_addr1 = '0;
      bus_if.req_wdata0 = '0;
      bus_if.req_wdata1 = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {bus_if.dma, bus_if.ack, bus_if.err, bus_if.bus_we,
                            bus_if.bus_addr, bus_if.bus_wdata, bus_if.rdata}, 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         check("idle_dma", bus_if.dma, 1'b0);
         push_exp(vecs[i].idx, 1'b0, vecs[i].exp_rdata);
         drive_req(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         wait_resp(a, e);
         bus_if.req[vecs[i].idx] = 1'b0;
         check("dma_latency", st_dma1, 1'b1);
         check("xfer_addr", st_addr, vecs[i].addr);
         check("we_window", st_we, vecs[i].we ? 4 : 0);
         check("wdata_leak", st_leak, 0);
         if (vecs[i].we) check("xfer_wdata", st_wdata, vecs[i].wdata);
         @(negedge clk);
         check("dma_hold_release", bus_if.dma, 1'b1);
         @(negedge clk);
         check("dma_released", bus_if.dma, 1'b0);
         repeat (3) @(negedge clk);
      end

      // Requester 1 streams writes; the cap forces one release after 4 acks.
      push_exp(1, 1'b0, 8'h5F);
      drive_req(1, 1'b1, 16'h0400, 8'h40);
      for (int i = 0; i < 5; i++) begin
         wait_resp(a, e);
         check("burst_ack", a, 2'b10);
         check("burst_addr", st_addr, 16'h0400 + 16'(i));
         check("burst_dma_low", st_low, (i == 4) ? 1 : 0);
         if (i < 4) begin
            push_exp(1, 1'b0, 8'h5F);
            drive_req(1, 1'b1, 16'h0401 + 16'(i), 8'h41 + 8'(i));
         end else begin
            bus_if.req[1] = 1'b0;
         end
      end
      repeat (6) @(negedge clk);

      // BA held high with a one-clk low glitch away from any rise.
      bus_if.ba = 1'b1;
      push_exp(0, 1'b1, 8'h5F);
      drive_req(0, 1'b0, 16'h1000, 8'h00);
      fork
         begin
            glitch_n = 0;
            while (!(bus_if.dma && !bus_if.phi2) && glitch_n < 100) begin
               @(negedge clk);
               glitch_n++;
            end
            bus_if.ba = 1'b0;
            @(negedge clk);
            bus_if.ba = 1'b1;
         end
         wait_resp(a, e);
      join
      bus_if.req[0] = 1'b0;
      check("stall_err", e, 2'b01);
      check("stall_no_ack", a, 2'b00);
      check("stall_rises", st_rise, BA_TIMEOUT);
      @(negedge clk);
      check("stall_dma_off", bus_if.dma, 1'b0);
      bus_if.ba = 1'b0;
      repeat (4) @(negedge clk);

      // Reset lands between rise and fall of the granted cycle.
      drive_req(0, 1'b0, 16'h2000, 8'h00);
      glitch_n = 0;
      while (!(bus_if.phi2 && bus_if.bus_addr == 16'h2000) && glitch_n < 100) begin
         @(negedge clk);
         glitch_n++;
      end
      check("mid_xfer_addr", bus_if.bus_addr, 16'h2000);
      reset = 1'b1;
      @(negedge clk);
      check("reset_dma_drop", bus_if.dma, 1'b0);
      check("reset_rdata", bus_if.rdata, 8'h00);
      reset = 1'b0;
      bus_if.req[0] = 1'b0;
      ack_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus_if.ack != 2'b00 || bus_if.err != 2'b00) ack_cnt++;
      end
      check("reset_no_resp", ack_cnt, 0);

      // Simultaneous requests after reset: 0, then 1, then 0 again.
      push_exp(0, 1'b0, 8'h77);
      push_exp(1, 1'b0, 8'h33);
      drive_req(0, 1'b0, 16'h3344, 8'h00);
      drive_req(1, 1'b0, 16'h5566, 8'h00);
      wait_resp(a, e);
      bus_if.req[0] = 1'b0;
      check("contend_first", a, 2'b01);
      wait_resp(a, e);
      bus_if.req[1] = 1'b0;
      check("contend_second", a, 2'b10);
      push_exp(0, 1'b0, 8'hFF);
      drive_req(0, 1'b0, 16'h7788, 8'h00);
      wait_resp(a, e);
      bus_if.req[0] = 1'b0;
      check("contend_third", a, 2'b01);
      repeat (20) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
